// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, screen/paddle/ball constants and the derived playfield limits.
package pong_pkg;

    localparam int H_ACTIVE        = 640;
    localparam int V_ACTIVE        = 480;
    localparam int PADDLE_HEIGHT_2 = 30;
    localparam int PADDLE_WIDTH    = 10;
    localparam int BALL_SIZE_2     = 3;
    localparam int BALL_SPEED      = 4;
    localparam int PADDLE_SPEED    = 4;
    localparam int SERVE_FRAMES    = 60;
    localparam int WIN_SCORE       = 9;
    localparam int DEBOUNCE_CYCLES = 250000;

    localparam logic [9:0] X_CENTRE = 10'(H_ACTIVE / 2);
    localparam logic [9:0] Y_CENTRE = 10'(V_ACTIVE / 2);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    typedef struct packed {
        logic [9:0] ball_y_min;
        logic [9:0] ball_y_max;
        logic [9:0] ball_x_min;
        logic [9:0] ball_x_max;
        logic [9:0] pad_min;
        logic [9:0] pad_max;
    } limits_t;

    // Ball limits are where the ball edge touches the wall or the paddle face.
    function automatic limits_t calc_limits();
        limits_t l;
        l.ball_y_min = 10'(BALL_SIZE_2);
        l.ball_y_max = 10'(V_ACTIVE - 1 - BALL_SIZE_2);
        l.ball_x_min = 10'(PADDLE_WIDTH + BALL_SIZE_2);
        l.ball_x_max = 10'(H_ACTIVE - PADDLE_WIDTH - BALL_SIZE_2);
        l.pad_min    = 10'(PADDLE_HEIGHT_2);
        l.pad_max    = 10'(V_ACTIVE - PADDLE_HEIGHT_2);
        return l;
    endfunction

    localparam limits_t LIM = calc_limits();

endpackage

// File: rtl/pong_if.sv
// pong_if: frame tick / switch inputs and registered game outputs of the pong sequencer.
//   frame_tick   one-cycle pulse at start of vertical blanking
//   sw[3:0]      raw switches: [0] left up/start, [1] left down, [2] right up, [3] right down
//   ball_x/y, ball_visible, paddle_l_y/paddle_r_y, score_l/score_r, state
// master = timing generator / consumer side, slave = the sequencer.
interface pong_if;
    import pong_pkg::*;

    logic       frame_tick;
    logic [3:0] sw;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       ball_visible;
    logic [9:0] paddle_l_y;
    logic [9:0] paddle_r_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [2:0] state;

    modport master (
        output frame_tick, sw,
        input  ball_x, ball_y, ball_visible, paddle_l_y, paddle_r_y, score_l, score_r, state
    );

    modport slave (
        input  frame_tick, sw,
        output ball_x, ball_y, ball_visible, paddle_l_y, paddle_r_y, score_l, score_r, state
    );

endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: 2-flop synchroniser followed by a stability counter.
//   clk_i, rst_n_i  clock, async active-low reset
//   sw_i            raw switch
//   level_o         debounced level, follows sw_i after DEBOUNCE_CYCLES equal samples
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sw_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], sw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Any sample equal to the current level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
            else cnt_d = cnt_q + 1'b1;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-synchronous pong sequencer (debounce, serve/play/score FSM, ball and paddles).
//   clk_i, rst_n_i  pixel clock, async active-low reset
//   bus (slave)     frame_tick + raw switches in; registered ball, paddles, scores and state out
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = pong_pkg::DEBOUNCE_CYCLES
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    pong_if.slave   bus
);

    localparam logic signed [10:0] STEP   = 11'(BALL_SPEED);
    localparam logic signed [10:0] REACH  = 11'(PADDLE_HEIGHT_2 + BALL_SIZE_2);
    localparam logic [9:0]         STEP_P = 10'(PADDLE_SPEED);
    localparam logic [5:0]         LAST_F = 6'(SERVE_FRAMES - 1);
    localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

    logic [3:0] sw_db;
    logic       sw1_prev_q;
    logic       start_q, start_d;

    state_e     state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d, pl_q, pl_d, pr_q, pr_d;
    logic       dx_pos_q, dx_pos_d, dy_pos_q, dy_pos_d, serve_pos_q, serve_pos_d;
    logic [3:0] sl_q, sl_d, sr_q, sr_d;
    logic [5:0] cnt_q, cnt_d;
    logic       vis_q, vis_d;

    logic signed [10:0] nx, ny, dl, dr;
    logic               hit_l, hit_r;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_db
            switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .sw_i    (bus.sw[g]),
                .level_o (sw_db[g])
            );
        end
    endgenerate

    function automatic logic [9:0] move_paddle(input logic [9:0] p, input logic up, input logic dn);
        return (up && !dn) ? ((p < LIM.pad_min + STEP_P) ? LIM.pad_min : p - STEP_P)
             : (dn && !up) ? ((p > LIM.pad_max - STEP_P) ? LIM.pad_max : p + STEP_P) : p;
    endfunction

    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s == WIN) ? s : s + 4'd1;
    endfunction

    // A press only counts for the tick that follows it; every tick consumes it.
    assign start_d = bus.frame_tick ? 1'b0 : (start_q | (sw_db[0] & ~sw1_prev_q));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sw1_prev_q  <= 1'b0;
            start_q     <= 1'b0;
            state_q     <= ST_IDLE;
            x_q         <= X_CENTRE;
            y_q         <= Y_CENTRE;
            pl_q        <= Y_CENTRE;
            pr_q        <= Y_CENTRE;
            dx_pos_q    <= 1'b1;
            dy_pos_q    <= 1'b1;
            serve_pos_q <= 1'b1;
            sl_q        <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            vis_q       <= 1'b0;
        end else begin
            sw1_prev_q  <= sw_db[0];
            start_q     <= start_d;
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pl_q        <= pl_d;
            pr_q        <= pr_d;
            dx_pos_q    <= dx_pos_d;
            dy_pos_q    <= dy_pos_d;
            serve_pos_q <= serve_pos_d;
            sl_q        <= sl_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            vis_q       <= vis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        pl_d        = pl_q;
        pr_d        = pr_q;
        dx_pos_d    = dx_pos_q;
        dy_pos_d    = dy_pos_q;
        serve_pos_d = serve_pos_q;
        sl_d        = sl_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        nx          = $signed({1'b0, x_q}) + (dx_pos_q ? STEP : -STEP);
        ny          = $signed({1'b0, y_q}) + (dy_pos_q ? STEP : -STEP);
        dl          = $signed({1'b0, y_q}) - $signed({1'b0, pl_q});
        dr          = $signed({1'b0, y_q}) - $signed({1'b0, pr_q});
        hit_l       = (dl < REACH) && (dl > -REACH);
        hit_r       = (dr < REACH) && (dr > -REACH);
        if (bus.frame_tick) begin
            if (state_q inside {ST_SERVE, ST_PLAY, ST_POINT}) begin
                pl_d = move_paddle(pl_q, sw_db[0], sw_db[1]);
                pr_d = move_paddle(pr_q, sw_db[2], sw_db[3]);
            end
            case (state_q)
                ST_IDLE: if (start_q) begin
                    sl_d        = '0;
                    sr_d        = '0;
                    serve_pos_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_SERVE;
                end
                ST_SERVE: if (cnt_q == LAST_F) begin
                    dx_pos_d = serve_pos_q;
                    dy_pos_d = 1'b1;
                    state_d  = ST_PLAY;
                end else cnt_d = cnt_q + 6'd1;
                ST_PLAY: begin
                    y_d = ny[9:0];
                    if (ny <= $signed({1'b0, LIM.ball_y_min})) begin
                        y_d      = LIM.ball_y_min;
                        dy_pos_d = 1'b1;
                    end else if (ny >= $signed({1'b0, LIM.ball_y_max})) begin
                        y_d      = LIM.ball_y_max;
                        dy_pos_d = 1'b0;
                    end
                    x_d = nx[9:0];
                    // On a miss the ball stops at its last column; it is hidden until re-centred.
                    if (dx_pos_q && nx >= $signed({1'b0, LIM.ball_x_max})) begin
                        if (hit_r) begin
                            x_d      = LIM.ball_x_max;
                            dx_pos_d = 1'b0;
                        end else begin
                            x_d         = x_q;
                            sl_d        = score_inc(sl_q);
                            serve_pos_d = 1'b0;
                            cnt_d       = '0;
                            state_d     = ST_POINT;
                        end
                    end else if (!dx_pos_q && nx <= $signed({1'b0, LIM.ball_x_min})) begin
                        if (hit_l) begin
                            x_d      = LIM.ball_x_min;
                            dx_pos_d = 1'b1;
                        end else begin
                            x_d         = x_q;
                            sr_d        = score_inc(sr_q);
                            serve_pos_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = ST_POINT;
                        end
                    end
                end
                ST_POINT: if (cnt_q == LAST_F) begin
                    state_d = (sl_q == WIN || sr_q == WIN) ? ST_GAME_OVER : ST_SERVE;
                    cnt_d   = '0;
                    x_d     = X_CENTRE;
                    y_d     = Y_CENTRE;
                end else cnt_d = cnt_q + 6'd1;
                ST_GAME_OVER: if (start_q) begin
                    state_d = ST_IDLE;
                    x_d     = X_CENTRE;
                    y_d     = Y_CENTRE;
                    pl_d    = Y_CENTRE;
                    pr_d    = Y_CENTRE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        vis_d = state_d inside {ST_SERVE, ST_PLAY};
    end

    assign bus.ball_x       = x_q;
    assign bus.ball_y       = y_q;
    assign bus.ball_visible = vis_q;
    assign bus.paddle_l_y   = pl_q;
    assign bus.paddle_r_y   = pr_q;
    assign bus.score_l      = sl_q;
    assign bus.score_r      = sr_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: randomized switch/tick stimulus checked against a behavioural pong model.
module tb_pong_game_ctrl;

    localparam int D = 8;
    localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    int       m_state, m_x, m_y, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_serve, m_frames;
    bit       m_start;
    bit [3:0] m_sw;

    pong_if bus();

    pong_game_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("state", int'(bus.state), m_state);
        chk("ball_x", int'(bus.ball_x), m_x);
        chk("ball_y", int'(bus.ball_y), m_y);
        chk("visible", int'(bus.ball_visible), int'(m_state == SERVE || m_state == PLAY));
        chk("paddle_l", int'(bus.paddle_l_y), m_pl);
        chk("paddle_r", int'(bus.paddle_r_y), m_pr);
        chk("score_l", int'(bus.score_l), m_sl);
        chk("score_r", int'(bus.score_r), m_sr);
    endtask

    task automatic model_reset();
        m_state = IDLE; m_x = 320; m_y = 240; m_dx = 4; m_dy = 4;
        m_pl = 240; m_pr = 240; m_sl = 0; m_sr = 0; m_serve = 4; m_frames = 0;
        m_start = 0; m_sw = 0;
    endtask

    function automatic int paddle_next(input int p, input bit up, input bit dn);
        if (up && !dn) return (p - 4 < 30) ? 30 : p - 4;
        if (dn && !up) return (p + 4 > 450) ? 450 : p + 4;
        return p;
    endfunction

    function automatic int abs_i(input int v);
        return v < 0 ? -v : v;
    endfunction

    // One frame of game rules; paddles seen by the hit test are the pre-tick ones.
    task automatic model_tick();
        int  nx, ny, npl, npr;
        bit  go, moving;
        go      = m_start;
        m_start = 0;
        moving  = (m_state == SERVE || m_state == PLAY || m_state == POINT);
        npl     = moving ? paddle_next(m_pl, m_sw[0], m_sw[1]) : m_pl;
        npr     = moving ? paddle_next(m_pr, m_sw[2], m_sw[3]) : m_pr;
        case (m_state)
            IDLE: if (go) begin
                m_sl = 0; m_sr = 0; m_serve = 4; m_frames = 0; m_state = SERVE;
            end
            SERVE: begin
                m_frames++;
                if (m_frames == 60) begin
                    m_dx = m_serve; m_dy = 4; m_state = PLAY;
                end
            end
            PLAY: begin
                nx = m_x + m_dx;
                ny = m_y + m_dy;
                if (m_dx > 0 && nx >= 627) begin
                    if (abs_i(m_y - m_pr) < 33) begin
                        nx = 627; m_dx = -4;
                    end else begin
                        nx = m_x; m_sl = (m_sl < 9) ? m_sl + 1 : 9; m_serve = -4;
                        m_frames = 0; m_state = POINT;
                    end
                end else if (m_dx < 0 && nx <= 13) begin
                    if (abs_i(m_y - m_pl) < 33) begin
                        nx = 13; m_dx = 4;
                    end else begin
                        nx = m_x; m_sr = (m_sr < 9) ? m_sr + 1 : 9; m_serve = 4;
                        m_frames = 0; m_state = POINT;
                    end
                end
                if (ny <= 3) begin
                    ny = 3; m_dy = 4;
                end else if (ny >= 476) begin
                    ny = 476; m_dy = -4;
                end
                m_x = nx;
                m_y = ny;
            end
            POINT: begin
                m_frames++;
                if (m_frames == 60) begin
                    m_state = (m_sl == 9 || m_sr == 9) ? OVER : SERVE;
                    m_frames = 0; m_x = 320; m_y = 240;
                end
            end
            default: if (go) begin
                m_state = IDLE; m_x = 320; m_y = 240; npl = 240; npr = 240;
            end
        endcase
        m_pl = npl;
        m_pr = npr;
    endtask

    task automatic do_tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        model_tick();
        check_all();
        repeat (2) @(negedge clk);
    endtask

    // Switch changes are held long enough to debounce before the next tick.
    task automatic set_sw(input logic [3:0] v);
        @(negedge clk);
        bus.sw = v;
        if (!m_sw[0] && v[0]) m_start = 1;
        m_sw = v;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.sw = '0;
        rst_n  = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (D + 6) @(negedge clk);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.sw         = '0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();
        repeat (3) do_tick();
        // Glitch on the start switch shorter than the debounce window.
        @(negedge clk);
        bus.sw = 4'b0001;
        repeat (D - 3) @(negedge clk);
        bus.sw = 4'b0000;
        repeat (D + 6) @(negedge clk);
        do_tick();
        // Real start press, then the full serve and a few play frames.
        set_sw(4'b0001);
        set_sw(4'b0000);
        repeat (70) do_tick();
        // Left up held into the clamp, then both left switches together.
        set_sw(4'b0001);
        repeat (60) do_tick();
        set_sw(4'b0011);
        repeat (5) do_tick();
        set_sw(4'b0000);
        for (int it = 0; it < 450; it++) begin
            repeat ($urandom_range(1, 20)) do_tick();
            set_sw(4'($urandom));
            if (it == 200) do_reset();
        end
        // Reset asserted wherever the game is now.
        repeat (10) do_tick();
        do_reset();
        do_tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-synchronous game sequencer for the VGA pong design. It debounces the four player switches and runs the serve/play/score/game-over state machine. Once per frame it updates ball and paddle positions and scores. It sits between the VGA timing generator, which supplies the frame tick, and the combinational pixel colouring and 7-segment logic, which consume its registered positions and scores.

## Interface
- H_ACTIVE, 640: visible columns
- V_ACTIVE, 480: visible rows
- PADDLE_HEIGHT_2, 30: paddle half-height (px)
- PADDLE_WIDTH, 10: paddle width (px)
- BALL_SIZE_2, 3: ball half-size (px)
- BALL_SPEED, 4: ball step per frame, both axes (px)
- PADDLE_SPEED, 4: paddle step per frame (px)
- SERVE_FRAMES, 60: frame ticks spent in SERVE and in POINT
- WIN_SCORE, 9: score that ends the game (≤15)
- DEBOUNCE_CYCLES, 250000: stable cycles required before a debounced switch changes
- i_Clk  in  1  pixel clock; single clock domain
- i_Rst_L  in  1  reset; asynchronous assert, active-low
- i_Frame_Tick  in  1  one-cycle pulse at the start of vertical blanking
- i_Switch_1..4  in  1 each  raw switches: 1 = left up/start, 2 = left down, 3 = right up, 4 = right down
- o_Ball_X, o_Ball_Y  out  10 each  ball centre
- o_Ball_Visible  out  1  ball drawn only in SERVE and PLAY
- o_Paddle_L_Y, o_Paddle_R_Y  out  10 each  paddle centres
- o_Score_L, o_Score_R  out  4 each  scores
- o_State  out  3  current state encoding

## Operation
- Debounce: each switch passes through a 2-flop synchroniser, then a counter. The debounced level takes the synchronised value only after DEBOUNCE_CYCLES consecutive equal samples.
- Start request: set on a debounced 0→1 edge of Switch_1. Cleared on every frame tick, so a stale press never carries into a later frame.
- All game updates occur only in the cycle where i_Frame_Tick = 1. Between ticks, all game registers hold.
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.
- IDLE:
  - Ball at (320,240), paddles at 240, scores hold, ball hidden.
  - On a tick with start request set: scores cleared, serve direction set to +x, go to SERVE.
- SERVE:
  - Ball centred; paddles move.
  - After SERVE_FRAMES ticks: dx = ±BALL_SPEED per serve direction, dy = +BALL_SPEED, go to PLAY.
- PLAY:
  - Compute next_x = x+dx and next_y = y+dy as signed 11-bit values.
  - Top/bottom: if next_y ≤ 3, then y = 3 and dy = +speed. If next_y ≥ 476, then y = 476 and dy = −speed.
  - Right edge (dx > 0, next_x ≥ 627): a hit when |y − paddle_R| < PADDLE_HEIGHT_2+BALL_SIZE_2. On a hit, x = 627 and dx is negated. On a miss, left scores and the state goes to POINT.
  - Left edge (dx < 0, next_x ≤ 13): mirror of the right edge, using paddle_L; a miss scores for right.
  - A vertical bounce and a horizontal event in the same tick are both applied.
- POINT:
  - Ball hidden; paddles move.
  - The scorer's score increments on entry and saturates at WIN_SCORE.
  - Serve direction points toward the player who lost the point.
  - After SERVE_FRAMES ticks: go to GAME_OVER if either score equals WIN_SCORE, otherwise go to SERVE.
- GAME_OVER: ball hidden, scores held. A start request at a tick goes to IDLE.
- Paddles:
  - Move in SERVE, PLAY and POINT.
  - Up switch: −PADDLE_SPEED. Down switch: +PADDLE_SPEED. Both switches pressed: no move.
  - Clamped to [PADDLE_HEIGHT_2, V_ACTIVE−PADDLE_HEIGHT_2], i.e. [30, 450].
- Frame counter: reset to 0 on entry to SERVE and to POINT; wraps only by state exit.

## Timing
- All outputs are registered. A tick at cycle N shows its new values at cycle N+1.
- Reset values:
  - o_State = IDLE.
  - o_Ball_X = 320, o_Ball_Y = 240, o_Ball_Visible = 0.
  - o_Paddle_L_Y = o_Paddle_R_Y = 240.
  - o_Score_L = o_Score_R = 0.
  - All debouncers and the start request cleared.
- Reset asserted mid-game returns everything to the reset values immediately, with no tick needed.
- Switch-to-debounced-level latency is 2 + DEBOUNCE_CYCLES cycles. Action then occurs at the next tick.

## Structure
- Shared package `pong_pkg`: the state encoding enum, screen and paddle constants, and a derived-limits function giving the 3/476/13/627/30/450 bounds.
- Sub-module `switch_debounce` (synchroniser + counter, DEBOUNCE_CYCLES parameter), instantiated four times.

## Test plan
- Reset mid-PLAY with ball at (500,100) → next cycle: IDLE, (320,240), scores 0/0, ball hidden.
- Switch_1 pulse shorter than DEBOUNCE_CYCLES → no start. Held for DEBOUNCE_CYCLES+2 → SERVE at the next tick, then PLAY after exactly 60 ticks with dx = +4, dy = +4.
- PLAY, ball (624,240), dx = +4, paddle_R = 240 → x = 627, dx = −4. Same setup with paddle_R = 100 → POINT, score_L 0→1, and the next serve has dx = −4.
- Corner case: ball (626,475), dx = dy = +4, paddle_R = 450 (hit) → x = 627, y = 476, dx = dy = −4 in one tick.
- Paddle_L at 32 with Switch_1 held → 30 and stays 30. Switches 1 and 2 both held → no change.
- Score_L at 8 plus a right miss → score_L = 9, then GAME_OVER after 60 ticks. Start request → IDLE, then scores 0/0 on the next serve.
